// File: rtl/rvvi_depacketizer.sv
// RVVI trace depacketizer: rebuilds one trace vector per Ethernet frame.
// Optional destination MAC filter: define RVVI_DEPKT_MACFILTER_EN.
module rvvi_depacketizer #(
    parameter int          XLEN       = 64,
    parameter int          MAX_CSRS   = 5,
    parameter int          RVVI_WIDTH = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
    parameter int          PAY_WORDS  = (RVVI_WIDTH + 31) / 32,
    parameter logic [15:0] ETHER_TYPE = 16'h005c,
    parameter logic [47:0] DST_MAC    = 48'h4502_1111_6843
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           RvviAxiRdata,
    input  logic [3:0]            RvviAxiRstrb,
    input  logic                  RvviAxiRvalid,
    input  logic                  RvviAxiRlast,
    output logic                  RvviAxiRready,
    output logic [RVVI_WIDTH-1:0] rvvi,
    output logic                  valid,
    input  logic                  RvviReady,
    output logic [15:0]           GoodFrames,
    output logic [15:0]           DropFrames
);

    localparam int KW = $clog2(PAY_WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(PAY_WORDS - 1);
    localparam int SW = (PAY_WORDS - 1) * 32;

    typedef enum logic [1:0] {HDR, PAY, DROP} state_e;

    state_e                state_q, state_d;
    logic [1:0]            hdr_q, hdr_d;
    logic [KW-1:0]         k_q, k_d;
    logic [SW-1:0]         shadow_q, shadow_d;
    logic [RVVI_WIDTH-1:0] rvvi_q, rvvi_d;
    logic                  valid_q, valid_d;
    logic [15:0]           good_q, good_d;
    logic [15:0]           drop_q, drop_d;
    logic                  xfer;
    logic                  last_slot;
    logic                  unused_ok;

`ifdef RVVI_DEPKT_MACFILTER_EN
    logic mac_bad_q, mac_bad_d;
    assign unused_ok = ^RvviAxiRstrb;
`else
    assign unused_ok = ^{RvviAxiRstrb, DST_MAC};
`endif

    assign last_slot = (k_q == K_LAST);
    // Stall only the final word while the output slot is still occupied.
    assign RvviAxiRready = !((state_q == PAY) && last_slot && valid_q && !RvviReady);
    assign xfer = RvviAxiRvalid && RvviAxiRready;

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        k_d      = k_q;
        shadow_d = shadow_q;
        rvvi_d   = rvvi_q;
        valid_d  = valid_q;
        good_d   = good_q;
        drop_d   = drop_q;
`ifdef RVVI_DEPKT_MACFILTER_EN
        mac_bad_d = mac_bad_q;
`endif
        if (valid_q && RvviReady) valid_d = 1'b0;
        if (xfer) begin
            unique case (state_q)
                HDR: begin
                    hdr_d = hdr_q + 2'd1;
`ifdef RVVI_DEPKT_MACFILTER_EN
                    if (hdr_q == 2'd0)
                        mac_bad_d = (RvviAxiRdata != DST_MAC[31:0]);
`endif
                    if (RvviAxiRlast) begin
                        drop_d = drop_q + 16'd1;
                        hdr_d  = 2'd0;
                    end
`ifdef RVVI_DEPKT_MACFILTER_EN
                    else if (hdr_q == 2'd1 &&
                             (mac_bad_q || RvviAxiRdata[15:0] != DST_MAC[47:32])) begin
                        drop_d  = drop_q + 16'd1;
                        hdr_d   = 2'd0;
                        state_d = DROP;
                    end
`endif
                    else if (hdr_q == 2'd3) begin
                        k_d = '0;
                        if (RvviAxiRdata[15:0] == ETHER_TYPE) begin
                            state_d = PAY;
                        end else begin
                            state_d = DROP;
                            drop_d  = drop_q + 16'd1;
                        end
                    end
                end
                PAY: begin
                    if (last_slot) begin
                        if (RvviAxiRlast) begin
                            // Final word is merged directly; it never lands in shadow.
                            rvvi_d  = RVVI_WIDTH'({RvviAxiRdata, shadow_q});
                            valid_d = 1'b1;
                            good_d  = good_q + 16'd1;
                            state_d = HDR;
                        end else begin
                            drop_d  = drop_q + 16'd1;
                            state_d = DROP;
                        end
                    end else if (RvviAxiRlast) begin
                        drop_d  = drop_q + 16'd1;
                        state_d = HDR;
                    end else begin
                        shadow_d[32*k_q +: 32] = RvviAxiRdata;
                        k_d = k_q + KW'(1);
                    end
                end
                DROP: begin
                    if (RvviAxiRlast) state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HDR;
            hdr_q    <= '0;
            k_q      <= '0;
            shadow_q <= '0;
            rvvi_q   <= '0;
            valid_q  <= 1'b0;
            good_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            k_q      <= k_d;
            shadow_q <= shadow_d;
            rvvi_q   <= rvvi_d;
            valid_q  <= valid_d;
            good_q   <= good_d;
            drop_q   <= drop_d;
        end
    end

`ifdef RVVI_DEPKT_MACFILTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mac_bad_q <= 1'b0;
        else       mac_bad_q <= mac_bad_d;
    end
`endif

    assign rvvi       = rvvi_q;
    assign valid      = valid_q;
    assign GoodFrames = good_q;
    assign DropFrames = drop_q;

endmodule
